// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph table and types used by both
// the display encoder and the scan decoder.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nib_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low g..a patterns, indexed by the hex nibble they show
    localparam seg_t GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup of a segment pattern into a hex nibble,
// with hit and blank flags.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  seg_t seg_i,
    output nib_t nib_o,
    output logic hit_o,
    output logic blank_o
);

    always_comb begin
        nib_o = '0;
        hit_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == GLYPH[i]) begin
                nib_o = nib_t'(i);
                hit_o = 1'b1;
            end
        end
    end

    assign blank_o = (seg_i == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decode.sv
// Scanned 7-segment bus receiver: sync, stability filter, glyph decode, frame/err.
// Optional watchdog clearing valid: define SEG7_SCAN_DECODE_TIMEOUT_EN.
module seg7_scan_decode
    import seg7_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int STABLE  = 16,
    parameter int TIMEOUT = 1048576
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [DIGITS-1:0]   dig_sel,
    input  logic [6:0]          seg,
    output logic [4*DIGITS-1:0] value,
    output logic [DIGITS-1:0]   valid,
    output logic                frame,
    output logic                err
);

    localparam int SW = DIGITS + 7;
    localparam int CW = $clog2(STABLE + 1);

    logic [SW-1:0]       sync_q, samp_q, prev_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   mask_q, mask_d, mask_n;
    logic [DIGITS-1:0]   sel;
    logic                frame_q, frame_d;
    logic                err_q, err_d;
    logic                same, ripe, onehot, commit;
    seg_t                sseg;
    nib_t                nib;
    logic                hit, blank;

    assign sel  = samp_q[SW-1:7];
    assign sseg = samp_q[6:0];

    seg7_glyph_decode u_dec (
        .seg_i   (sseg),
        .nib_o   (nib),
        .hit_o   (hit),
        .blank_o (blank)
    );

`ifdef SEG7_SCAN_DECODE_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          fire;
`endif

    always_comb begin
        same   = (samp_q == prev_q);
        onehot = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
        // Fires once per stable window: the counter saturates past this point
        ripe   = same && (cnt_q == CW'(STABLE - 1));
        commit = ripe && onehot;

        if (!same)
            cnt_d = '0;
        else if (cnt_q == CW'(STABLE))
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CW'(1);

        value_d = value_q;
        valid_d = valid_q;
        mask_d  = mask_q;
        mask_n  = '0;
        frame_d = 1'b0;
        err_d   = 1'b0;

`ifdef SEG7_SCAN_DECODE_TIMEOUT_EN
        fire = (wd_q == WW'(TIMEOUT - 1));
        wd_d = (commit || fire) ? '0 : wd_q + WW'(1);
        if (fire) begin
            valid_d = '0;
            mask_d  = '0;
        end
`endif

        if (commit) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (sel[d]) begin
                    if (hit)
                        value_d[4*d +: 4] = nib;
                    valid_d[d] = hit;
                end
            end
            err_d  = !hit && !blank;
            mask_n = mask_d | sel;
            if (&mask_n) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end else begin
                mask_d  = mask_n;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            samp_q  <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            valid_q <= '0;
            mask_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {dig_sel, seg};
            samp_q  <= sync_q;
            prev_q  <= samp_q;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            mask_q  <= mask_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

`ifdef SEG7_SCAN_DECODE_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            wd_q <= '0;
        else
            wd_q <= wd_d;
    end
`endif

    assign value = value_q;
    assign valid = valid_q;
    assign frame = frame_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seg7_scan_decode.sv
// Random and directed bench for seg7_scan_decode against a sample-history model.
module tb_seg7_scan_decode;

    localparam int D  = 4;
    localparam int ST = 4;
    localparam int TO = 64;
    localparam int W  = D + 7;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic [D-1:0] dig_sel = '0;
    logic [6:0]   seg     = '0;
    logic [4*D-1:0] value;
    logic [D-1:0] valid;
    logic         frame;
    logic         err;

    seg7_scan_decode #(
        .DIGITS  (D),
        .STABLE  (ST),
        .TIMEOUT (TO)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .dig_sel (dig_sel),
        .seg     (seg),
        .value   (value),
        .valid   (valid),
        .frame   (frame),
        .err     (err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int nframe = 0;
    int nerr  = 0;
    bit chk_en = 1'b0;

    logic [6:0] gly [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [W-1:0] hist [$];
    logic [3:0]   m_val [D];
    logic [D-1:0] m_valid, m_mask;
    logic         m_frame, m_err;
    int           since;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*D-1:0] m_value();
        logic [4*D-1:0] v;
        for (int d = 0; d < D; d++) v[4*d +: 4] = m_val[d];
        return v;
    endfunction

    // Three zero samples stand for the cleared synchroniser after reset
    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back('0);
        for (int d = 0; d < D; d++) m_val[d] = '0;
        m_valid = '0;
        m_mask  = '0;
        m_frame = 1'b0;
        m_err   = 1'b0;
        since   = 0;
    endtask

    // A commit happens when the sample two edges old ends a run of exactly ST+1
    task automatic model_step();
        int p, r, dd, h;
        logic [D-1:0] s;
        logic [6:0] g;
        bit commit, fire;
        hist.push_back({dig_sel, seg});
        if (hist.size() > ST + 8) void'(hist.pop_front());
        m_frame = 1'b0;
        m_err   = 1'b0;
        p = hist.size() - 3;
        r = 1;
        while (p - r >= 0 && hist[p-r] == hist[p]) r++;
        s = hist[p][W-1:7];
        g = hist[p][6:0];
        commit = (r == ST + 1) && ($countones(s) == 1);
        fire = 1'b0;
`ifdef SEG7_SCAN_DECODE_TIMEOUT_EN
        fire = (since == TO - 1);
        if (fire) begin
            m_valid = '0;
            m_mask  = '0;
        end
`endif
        if (commit) begin
            dd = 0;
            for (int i = 0; i < D; i++) if (s[i]) dd = i;
            h = -1;
            for (int i = 0; i < 16; i++) if (gly[i] == g) h = i;
            if (h >= 0) begin
                m_val[dd]   = 4'(h);
                m_valid[dd] = 1'b1;
            end else begin
                m_valid[dd] = 1'b0;
                m_err = (g != 7'h7F);
            end
            m_mask[dd] = 1'b1;
            if (m_mask == '1) begin
                m_frame = 1'b1;
                m_mask  = '0;
            end
        end
        since = (commit || fire) ? 0 : since + 1;
    endtask

    initial forever begin
        @(posedge clock);
        if (reset_n) model_step();
    end

    initial forever begin
        @(negedge clock);
        if (reset_n && chk_en) begin
            check("value", 32'(value), 32'(m_value()));
            check("valid", 32'(valid), 32'(m_valid));
            check("frame", 32'(frame), 32'(m_frame));
            check("err",   32'(err),   32'(m_err));
            if (frame) nframe++;
            if (err) nerr++;
        end
    end

    task automatic drive(logic [D-1:0] s, logic [6:0] g, int n);
        dig_sel = s;
        seg     = g;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0, e0, rs, hold;
        logic [D-1:0] s;
        logic [6:0] g;
        model_reset();
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("rst_value", 32'(value), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_frame", 32'(frame), 32'h0);
        check("rst_err",   32'(err),   32'h0);
        chk_en = 1'b1;

        dig_sel = 4'b0100;
        seg     = 7'h24;
        repeat (6) @(negedge clock);
        check("lat_early", 32'(valid), 32'h0);
        @(negedge clock);
        check("lat_valid", 32'(valid), 32'b0100);
        check("lat_value", 32'(value[11:8]), 32'h2);
        check("lat_err",   32'(err), 32'h0);

        f0 = nframe;
        drive(4'b1000, 7'h0E, 8);
        drive(4'b0100, 7'h00, 8);
        drive(4'b0010, 7'h79, 8);
        drive(4'b0001, 7'h40, 8);
        check("scan_value", 32'(value), 32'hF810);
        check("scan_valid", 32'(valid), 32'hF);
        check("scan_frames", 32'(nframe - f0), 32'd1);

        e0 = nerr;
        drive(4'b0001, 7'h7F, 8);
        check("blank_valid", 32'(valid), 32'b1110);
        check("blank_err", 32'(nerr - e0), 32'd0);
        drive(4'b0001, 7'h55, 8);
        check("ill_err", 32'(nerr - e0), 32'd1);
        check("ill_value", 32'(value[3:0]), 32'h0);
        check("ill_valid", 32'(valid), 32'b1110);

        e0 = nerr;
        for (int i = 0; i < 10; i++) drive(4'b0001, (i % 2) ? 7'h79 : 7'h40, 2);
        drive(4'b0011, 7'h40, 10);
        check("glitch_value", 32'(value), 32'hF810);
        check("glitch_valid", 32'(valid), 32'b1110);
        check("glitch_err", 32'(nerr - e0), 32'd0);

        repeat (400) begin
            rs = $urandom_range(0, 19);
            if (rs < 14) s = D'(1) << $urandom_range(0, D - 1);
            else if (rs < 17) s = '0;
            else s = D'($urandom);
            rs = $urandom_range(0, 9);
            if (rs < 5) g = gly[$urandom_range(0, 15)];
            else if (rs < 7) g = 7'h7F;
            else g = 7'($urandom);
            hold = $urandom_range(1, 10);
            drive(s, g, hold);
        end

        #3 reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_value", 32'(value), 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_frame", 32'(frame), 32'h0);
        check("mid_rst_err",   32'(err),   32'h0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);

        drive(4'b0010, 7'h79, 8);
        check("to_commit_valid", 32'(valid), 32'b0010);
        check("to_commit_value", 32'(value[7:4]), 32'h1);
        repeat (TO + 10) @(negedge clock);
`ifdef SEG7_SCAN_DECODE_TIMEOUT_EN
        check("to_valid", 32'(valid), 32'h0);
`else
        check("to_valid", 32'(valid), 32'b0010);
`endif
        check("to_value", 32'(value[7:4]), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
